hamming_secded_dec_pipe: RTL and testbench
==========================================

// Module: hamming_secded_dec_pipe
// PURPOSE
//  Parametrised, pipelined SEC-DED Hamming decoder for the SEU-protection IP.
//  Accepts codewords over a valid/ready stream and returns corrected data with CE/UE flags.
//  Also returns a re-encoded scrub codeword for memory write-back.
//  Keeps saturating CE/UE counters and a first-error log for the PMU/safety unit.
// PARAMETERS
//  DATA_WIDTH  26  data bits per word (>=4)
//  CNT_WIDTH   16  width of each error counter
//  N_CHECKB    (local) smallest r with 2**r >= DATA_WIDTH+r+1 (26->5, 32->6, 64->7)
//  CW_WIDTH    (local) DATA_WIDTH+N_CHECKB+1
// PORTS
//  clk_i           in   1           clock
//  rst_i           in   1           synchronous, active-high reset
//  in_valid_i      in   1           codeword valid
//  in_ready_o      out  1           decoder can accept
//  in_cw_i         in   CW_WIDTH    codeword; bit0 overall parity, bits 2**k check, rest data LSB-first
//  out_valid_o     out  1           result valid
//  out_ready_i     in   1           consumer accepts result
//  out_data_o      out  DATA_WIDTH  corrected data
//  out_ce_o        out  1           correctable error in this word
//  out_ue_o        out  1           uncorrectable error in this word
//  out_syndrome_o  out  N_CHECKB    raw syndrome
//  scrub_cw_o      out  CW_WIDTH    re-encoded corrected codeword
//  clr_i           in   1           clear counters and log
//  ce_cnt_o        out  CNT_WIDTH   saturating CE count
//  ue_cnt_o        out  CNT_WIDTH   saturating UE count
//  log_valid_o     out  1           log holds first error since reset/clear
//  log_ue_o        out  1           logged error was UE
//  log_syndrome_o  out  N_CHECKB    logged syndrome
// BEHAVIOUR
//  - Reset: all outputs 0. in_ready_o = !rst_i && (!out_valid_o || out_ready_i).
//  - Transfer: in_valid_i & in_ready_o. Latency 1 cycle; throughput 1 word/cycle.
//  - Output register holds all fields stable while out_valid_o & !out_ready_i.
//  - Syndrome s = XOR of positions with bit k set, for each k. Overall parity p = ^in_cw_i.
//  - Classification:
//      s==0, p==0          -> clean.
//      s==0, p==1          -> CE; parity bit0 flipped; data unchanged.
//      s!=0, p==1, s<CW    -> CE; flip position s.
//      s>=CW, p==1         -> UE; out-of-range syndrome.
//      s!=0, p==0          -> UE; double error.
//  - On UE: out_data_o = uncorrected data bits. scrub_cw_o = in_cw_i unmodified; never re-encode garbage.
//  - On clean/CE: scrub_cw_o = encode(out_data_o). All check bits and bit0 are regenerated.
//  - Counters:
//      +1 per transfer with CE/UE, saturating at all-ones.
//      clr_i clears first; an event in the same cycle then counts, giving 1.
//  - Log:
//      Captures the first error transfer while log_valid_o==0. Later errors are ignored.
//      clr_i drops log_valid_o. An error in the same cycle as clr_i is logged.
//  - rst_i mid-stream: the in-flight word is discarded; out_valid_o=0 the next cycle.
// STRUCTURE
//  - Package seu_hamming_pkg:
//      function num_checkb(dw), function cw_width(dw).
//      function is_pow2(pos) for data-position mapping.
//      typedef enum {ERR_NONE, ERR_CE, ERR_UE} err_e.
//  - Sub-module hamming_secded_enc #(DATA_WIDTH): combinational encoder, generate-loop based.
//    Reused for scrub_cw_o and by the bench.
//  - Decoder core: generate loops over positions. No hand-listed bit equations.
// TESTING
//  - DW=26, in_cw=32'h0000_0000 -> data 0, ce=0, ue=0, scrub 0, 1-cycle latency.
//  - DW=26, in_cw=32'h0000_0008 (pos3) -> data 0, ce=1, s=3, scrub 0, ce_cnt=1, log_valid=1, log_syndrome=3.
//  - DW=26, in_cw=32'h0000_0018 (pos3,4) -> ue=1, s=7, scrub=32'h18, ue_cnt=1; log keeps the earlier CE.
//  - DW=26, in_cw=32'h0000_0001 -> ce=1, s=0, data 0, scrub 0.
//  - DW=32, cw with positions 32,8,1 flipped -> s=41>=39, p=1 -> ue=1.
//  - Backpressure: hold out_ready_i=0 3 cycles -> in_ready_o=0 and output stable.
//    CNT_WIDTH=2 with 5 CEs -> ce_cnt=3. clr_i with a CE -> ce_cnt=1.

Source files
------------

// File: rtl/seu_hamming_pkg.sv
// Shared types and elaboration-time helpers for the SEC-DED Hamming encoder/decoder.
package seu_hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CE   = 2'd1,
    ERR_UE   = 2'd2
  } err_e;

  // Smallest r with 2**r >= dw + r + 1
  function automatic int unsigned num_checkb(input int unsigned dw);
    int unsigned res;
    res = 0;
    for (int unsigned r = 30; r > 0; r--) begin
      if ((32'd1 << r) >= dw + r + 32'd1) res = r;
    end
    return res;
  endfunction

  // Codeword width: data + Hamming check bits + overall parity bit
  function automatic int unsigned cw_width(input int unsigned dw);
    return dw + num_checkb(dw) + 32'd1;
  endfunction

  // Power-of-two positions carry check bits
  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 32'd1)) == 0);
  endfunction

  // Data bit index carried at a (non power-of-two, >=3) codeword position
  function automatic int unsigned data_idx(input int unsigned pos);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned q = 3; q < pos; q++) begin
      if (!is_pow2(q)) cnt++;
    end
    return cnt;
  endfunction

  // Codeword position carrying data bit idx
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned q = 3; q < 4096; q++) begin
      if (!is_pow2(q)) begin
        if (cnt == idx && res == 0) res = q;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_secded_enc.sv
// Combinational SEC-DED encoder: places data, regenerates check bits and overall parity.
module hamming_secded_enc
  import seu_hamming_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 26,
  localparam int unsigned N_CHECKB  = num_checkb(DATA_WIDTH),
  localparam int unsigned CW_WIDTH  = cw_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW_WIDTH-1:0]   enc_cw_c
);

  logic [CW_WIDTH-1:0] w_placed;
  logic [CW_WIDTH-1:0] w_body;
  logic [N_CHECKB-1:0] w_chk;

  // Scatter data bits onto non power-of-two positions
  for (genvar p = 0; p < CW_WIDTH; p++) begin : g_place
    if (p == 0 || is_pow2(p)) begin : g_hole
      assign w_placed[p] = 1'b0;
    end else begin : g_data
      assign w_placed[p] = data_i[data_idx(p)];
    end
  end

  // Check bit k covers every position with bit k set
  for (genvar k = 0; k < N_CHECKB; k++) begin : g_chk
    logic [CW_WIDTH-1:0] w_mask;
    for (genvar p = 0; p < CW_WIDTH; p++) begin : g_mask
      assign w_mask[p] = 1'((p >> k) & 1);
    end
    assign w_chk[k] = ^(w_placed & w_mask);
  end

  // Drop check bits into their power-of-two slots
  for (genvar p = 0; p < CW_WIDTH; p++) begin : g_body
    if (p == 0) begin : g_par
      assign w_body[p] = 1'b0;
    end else if (is_pow2(p)) begin : g_cb
      assign w_body[p] = w_chk[$clog2(p)];
    end else begin : g_db
      assign w_body[p] = w_placed[p];
    end
  end

  // Overall parity makes the full codeword even
  assign enc_cw_c = {w_body[CW_WIDTH-1:1], ^w_body};

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined SEC-DED decoder with scrub re-encode, saturating error counters and first-error log.
module hamming_secded_dec_pipe
  import seu_hamming_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned N_CHECKB  = num_checkb(DATA_WIDTH),
  localparam int unsigned CW_WIDTH  = cw_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CW_WIDTH-1:0]   in_cw_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ce_o,
  output logic                  out_ue_o,
  output logic [N_CHECKB-1:0]   out_syndrome_o,
  output logic [CW_WIDTH-1:0]   scrub_cw_o,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  ce_cnt_o,
  output logic [CNT_WIDTH-1:0]  ue_cnt_o,
  output logic                  log_valid_o,
  output logic                  log_ue_o,
  output logic [N_CHECKB-1:0]   log_syndrome_o
);

  logic [N_CHECKB-1:0]   w_syn;
  logic                  w_par;
  err_e                  w_err;
  logic [DATA_WIDTH-1:0] w_data;
  logic [CW_WIDTH-1:0]   w_enc;
  logic [CW_WIDTH-1:0]   w_scrub;
  logic                  w_xfer;
  logic [CNT_WIDTH-1:0]  w_ce_base, w_ue_base, w_ce_nxt, w_ue_nxt;
  logic                  w_log_valid_nxt, w_log_ue_nxt;
  logic [N_CHECKB-1:0]   w_log_syn_nxt;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_ce, r_out_ue;
  logic [N_CHECKB-1:0]   r_out_syn;
  logic [CW_WIDTH-1:0]   r_scrub;
  logic [CNT_WIDTH-1:0]  r_ce_cnt, r_ue_cnt;
  logic                  r_log_valid, r_log_ue;
  logic [N_CHECKB-1:0]   r_log_syn;

  assign in_ready_o = !rst_i && (!r_out_valid || out_ready_i);
  assign w_xfer     = in_valid_i && in_ready_o;

  // Syndrome bit k: parity over every position with bit k set
  for (genvar k = 0; k < N_CHECKB; k++) begin : g_syn
    logic [CW_WIDTH-1:0] w_mask;
    for (genvar p = 0; p < CW_WIDTH; p++) begin : g_mask
      assign w_mask[p] = 1'((p >> k) & 1);
    end
    assign w_syn[k] = ^(in_cw_i & w_mask);
  end

  assign w_par = ^in_cw_i;

  // Classify: odd parity with in-range syndrome is a single error, anything else nonzero is UE
  always_comb begin
    w_err = ERR_NONE;
    if (w_syn != '0 || w_par) begin
      if (w_par && (32'(w_syn) < CW_WIDTH)) w_err = ERR_CE;
      else                                  w_err = ERR_UE;
    end
  end

  // Gather data bits, flipping the one the syndrome points at on a CE
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data
    localparam int unsigned POS = data_pos(i);
    assign w_data[i] = in_cw_i[POS] ^ ((w_err == ERR_CE) && (w_syn == N_CHECKB'(POS)));
  end

  hamming_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data_i   (w_data),
    .enc_cw_c (w_enc)
  );

  // A UE word is written back untouched rather than re-encoding garbage
  assign w_scrub = (w_err == ERR_UE) ? in_cw_i : w_enc;

  // Next counter values: clear first, then a same-cycle event counts with saturation
  always_comb begin
    w_ce_base = clr_i ? '0 : r_ce_cnt;
    w_ue_base = clr_i ? '0 : r_ue_cnt;
    w_ce_nxt  = w_ce_base;
    w_ue_nxt  = w_ue_base;
    if (w_xfer && w_err == ERR_CE && w_ce_base != '1) w_ce_nxt = w_ce_base + CNT_WIDTH'(1);
    if (w_xfer && w_err == ERR_UE && w_ue_base != '1) w_ue_nxt = w_ue_base + CNT_WIDTH'(1);
  end

  // Next log state: clear drops it, first error after reset/clear is captured
  always_comb begin
    w_log_valid_nxt = r_log_valid;
    w_log_ue_nxt    = r_log_ue;
    w_log_syn_nxt   = r_log_syn;
    if (clr_i) begin
      w_log_valid_nxt = 1'b0;
      w_log_ue_nxt    = 1'b0;
      w_log_syn_nxt   = '0;
    end
    if (w_xfer && w_err != ERR_NONE && (!r_log_valid || clr_i)) begin
      w_log_valid_nxt = 1'b1;
      w_log_ue_nxt    = (w_err == ERR_UE);
      w_log_syn_nxt   = w_syn;
    end
  end

  // Output stage: load on accept, hold while stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ce    <= 1'b0;
      r_out_ue    <= 1'b0;
      r_out_syn   <= '0;
      r_scrub     <= '0;
    end else if (in_ready_o) begin
      r_out_valid <= in_valid_i;
      if (in_valid_i) begin
        r_out_data <= w_data;
        r_out_ce   <= (w_err == ERR_CE);
        r_out_ue   <= (w_err == ERR_UE);
        r_out_syn  <= w_syn;
        r_scrub    <= w_scrub;
      end
    end
  end

  // Counter and log state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ce_cnt    <= '0;
      r_ue_cnt    <= '0;
      r_log_valid <= 1'b0;
      r_log_ue    <= 1'b0;
      r_log_syn   <= '0;
    end else begin
      r_ce_cnt    <= w_ce_nxt;
      r_ue_cnt    <= w_ue_nxt;
      r_log_valid <= w_log_valid_nxt;
      r_log_ue    <= w_log_ue_nxt;
      r_log_syn   <= w_log_syn_nxt;
    end
  end

  assign out_valid_o    = r_out_valid;
  assign out_data_o     = r_out_data;
  assign out_ce_o       = r_out_ce;
  assign out_ue_o       = r_out_ue;
  assign out_syndrome_o = r_out_syn;
  assign scrub_cw_o     = r_scrub;
  assign ce_cnt_o       = r_ce_cnt;
  assign ue_cnt_o       = r_ue_cnt;
  assign log_valid_o    = r_log_valid;
  assign log_ue_o       = r_log_ue;
  assign log_syndrome_o = r_log_syn;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Scoreboard bench for the pipelined SEC-DED decoder (DW=26/CNT=2 main instance, DW=32 side instance).
module tb_hamming_secded_dec_pipe;

  typedef struct {
    logic [25:0] data;
    logic        ce;
    logic        ue;
    logic [4:0]  syn;
    logic [31:0] scrub;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_cw = '0;
  logic        out_ready = 1'b1;
  logic        clr = 1'b0;
  logic        in_ready, out_valid, out_ce, out_ue, log_valid, log_ue;
  logic [25:0] out_data;
  logic [4:0]  out_syn, log_syn;
  logic [31:0] scrub;
  logic [1:0]  ce_cnt, ue_cnt;

  logic        d32_valid = 1'b0;
  logic [38:0] d32_cw = '0;
  logic        d32_in_ready, d32_out_valid, d32_ce, d32_ue, d32_log_valid, d32_log_ue;
  logic [31:0] d32_data;
  logic [5:0]  d32_syn, d32_log_syn;
  logic [38:0] d32_scrub;
  logic [15:0] d32_ce_cnt, d32_ue_cnt;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  int   m_ce = 0, m_ue = 0;
  logic m_log_v = 0, m_log_ue = 0;
  logic [4:0] m_log_syn = '0;
  bit   rnd_ready = 0;

  always #5 clk = ~clk;

  hamming_secded_dec_pipe #(.DATA_WIDTH(26), .CNT_WIDTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_cw_i(in_cw),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_ce_o(out_ce),
    .out_ue_o(out_ue), .out_syndrome_o(out_syn), .scrub_cw_o(scrub), .clr_i(clr),
    .ce_cnt_o(ce_cnt), .ue_cnt_o(ue_cnt), .log_valid_o(log_valid), .log_ue_o(log_ue),
    .log_syndrome_o(log_syn)
  );

  hamming_secded_dec_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(d32_valid), .in_ready_o(d32_in_ready), .in_cw_i(d32_cw),
    .out_valid_o(d32_out_valid), .out_ready_i(1'b1), .out_data_o(d32_data), .out_ce_o(d32_ce),
    .out_ue_o(d32_ue), .out_syndrome_o(d32_syn), .scrub_cw_o(d32_scrub), .clr_i(1'b0),
    .ce_cnt_o(d32_ce_cnt), .ue_cnt_o(d32_ue_cnt), .log_valid_o(d32_log_valid),
    .log_ue_o(d32_log_ue), .log_syndrome_o(d32_log_syn)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: sequential placement, then check bits by coverage
  function automatic logic [31:0] m_enc(input logic [25:0] d);
    logic [31:0] cw;
    int j;
    logic c;
    cw = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      c = 1'b0;
      for (int p = 1; p < 32; p++) if (((p >> k) & 1) == 1) c = c ^ cw[p];
      cw[1 << k] = c;
    end
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  // Reference decoder: syndrome is the XOR of indices of all set bits
  function automatic exp_t m_dec(input logic [31:0] cw);
    exp_t e;
    logic [31:0] corr;
    logic par;
    int j;
    e.syn = '0;
    for (int p = 1; p < 32; p++) if (cw[p]) e.syn = e.syn ^ 5'(p);
    par  = ^cw;
    e.ce = 1'b0;
    e.ue = 1'b0;
    if (par) e.ce = 1'b1;
    else if (e.syn != 0) e.ue = 1'b1;
    corr = cw;
    if (e.ce) corr[e.syn] = ~corr[e.syn];
    j = 0;
    e.data = '0;
    for (int p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[j] = corr[p];
        j++;
      end
    end
    e.scrub = e.ue ? cw : m_enc(e.data);
    return e;
  endfunction

  task automatic model_update(input exp_t e, input logic do_clr);
    int cb, ub;
    cb = do_clr ? 0 : m_ce;
    ub = do_clr ? 0 : m_ue;
    m_ce = (e.ce && cb < 3) ? cb + 1 : cb;
    m_ue = (e.ue && ub < 3) ? ub + 1 : ub;
    if (do_clr) begin
      m_log_v = 0; m_log_ue = 0; m_log_syn = '0;
    end
    if ((e.ce || e.ue) && (!m_log_v || do_clr)) begin
      m_log_v = 1; m_log_ue = e.ue; m_log_syn = e.syn;
    end
  endtask

  // Drive one word; push its expectation at the accepting edge
  task automatic send(input logic [31:0] cw, input logic do_clr);
    int cyc;
    exp_t e;
    cyc = 0;
    in_valid = 1'b1;
    in_cw = cw;
    clr = do_clr;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) check_val("send_timeout", 64'd0, 64'd1);
    else begin
      e = m_dec(cw);
      sb.push_back(e);
      model_update(e, do_clr);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Compare every delivered word against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check_val("sb_empty", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check_val("data", 64'(out_data), 64'(e.data));
        check_val("ce", 64'(out_ce), 64'(e.ce));
        check_val("ue", 64'(out_ue), 64'(e.ue));
        check_val("syn", 64'(out_syn), 64'(e.syn));
        check_val("scrub", 64'(scrub), 64'(e.scrub));
      end
    end
  end

  // Random output backpressure during the random phase
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cw, a_cw, b_cw;
    logic [25:0] d;
    exp_t hold;
    int nf, b1, b2;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_ce_cnt", 64'(ce_cnt), 64'd0);
    check_val("rst_log_valid", 64'(log_valid), 64'd0);
    check_val("rst_scrub", 64'(scrub), 64'd0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

    // DW=32: positions 32,8,1 give syndrome 41, beyond the 39-bit codeword
    d32_cw = (39'd1 << 32) | (39'd1 << 8) | (39'd1 << 1);
    d32_valid = 1'b1;
    @(posedge clk);
    #1;
    d32_valid = 1'b0;
    check_val("d32_valid", 64'(d32_out_valid), 64'd1);
    check_val("d32_ue", 64'(d32_ue), 64'd1);
    check_val("d32_ce", 64'(d32_ce), 64'd0);
    check_val("d32_syn", 64'(d32_syn), 64'd41);
    check_val("d32_scrub", 64'(d32_scrub), 64'(d32_cw));
    check_val("d32_ue_cnt", 64'(d32_ue_cnt), 64'd1);
    check_val("d32_log_syn", 64'(d32_log_syn), 64'd41);

    // Directed words
    send(32'h0000_0000, 1'b0);
    check_val("latency", 64'(out_valid), 64'd1);
    check_val("clean_scrub", 64'(scrub), 64'd0);
    send(32'h0000_0008, 1'b0);
    check_val("ce_syn3", 64'(out_syn), 64'd3);
    check_val("ce_cnt_1", 64'(ce_cnt), 64'd1);
    check_val("log_valid_1", 64'(log_valid), 64'd1);
    check_val("log_syn_3", 64'(log_syn), 64'd3);
    send(32'h0000_0018, 1'b0);
    check_val("ue_flag", 64'(out_ue), 64'd1);
    check_val("ue_scrub", 64'(scrub), 64'h18);
    check_val("ue_cnt_1", 64'(ue_cnt), 64'd1);
    check_val("log_keeps_ce", 64'(log_syn), 64'd3);
    check_val("log_ue_0", 64'(log_ue), 64'd0);
    send(32'h0000_0001, 1'b0);
    check_val("p0_ce", 64'(out_ce), 64'd1);
    check_val("p0_syn", 64'(out_syn), 64'd0);
    check_val("ce_cnt_2", 64'(ce_cnt), 64'd2);

    // Saturation at 2'b11
    for (int i = 0; i < 5; i++) begin
      cw = m_enc(26'($urandom));
      cw[$urandom_range(0, 31)] ^= 1'b1;
      send(cw, 1'b0);
    end
    check_val("ce_cnt_sat", 64'(ce_cnt), 64'd3);

    // Clear together with a CE
    send(32'h0000_0008, 1'b1);
    check_val("clr_ce_cnt", 64'(ce_cnt), 64'd1);
    check_val("clr_ue_cnt", 64'(ue_cnt), 64'd0);
    check_val("clr_log_valid", 64'(log_valid), 64'd1);
    check_val("clr_log_ue", 64'(log_ue), 64'd0);

    // Backpressure: output must hold while stalled
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a_cw = m_enc(26'h2A5_5A5A) ^ 32'h0000_0020;
    b_cw = m_enc(26'h155_AA55);
    send(a_cw, 1'b0);
    hold = m_dec(a_cw);
    in_valid = 1'b1;
    in_cw = b_cw;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      check_val("bp_out_valid", 64'(out_valid), 64'd1);
      check_val("bp_data", 64'(out_data), 64'(hold.data));
      check_val("bp_scrub", 64'(scrub), 64'(hold.scrub));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(b_cw, 1'b0);

    // Random words with 0/1/2 flips under random backpressure
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      d = 26'($urandom);
      cw = m_enc(d);
      nf = $urandom_range(0, 2);
      b1 = $urandom_range(0, 31);
      b2 = (b1 + $urandom_range(1, 31)) % 32;
      if (nf >= 1) cw[b1] ^= 1'b1;
      if (nf == 2) cw[b2] ^= 1'b1;
      send(cw, 1'b0);
    end
    rnd_ready = 0;
    #2;
    out_ready = 1'b1;
    drain();
    check_val("end_ce_cnt", 64'(ce_cnt), 64'(m_ce));
    check_val("end_ue_cnt", 64'(ue_cnt), 64'(m_ue));
    check_val("end_log_valid", 64'(log_valid), 64'(m_log_v));
    check_val("end_log_ue", 64'(log_ue), 64'(m_log_ue));
    check_val("end_log_syn", 64'(log_syn), 64'(m_log_syn));

    // Reset with a word in flight discards it
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h0000_0008, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_ce_cnt", 64'(ce_cnt), 64'd0);
    check_val("mid_rst_log", 64'(log_valid), 64'd0);
    void'(sb.pop_back());
    m_ce = 0; m_ue = 0; m_log_v = 0; m_log_ue = 0; m_log_syn = '0;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_0001, 1'b0);
    check_val("after_rst_ce_cnt", 64'(ce_cnt), 64'd1);
    check_val("after_rst_log_syn", 64'(log_syn), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
